// File: rtl/fpga2_rx_checker.sv
`default_nettype none
// ============================================================================
// Module   : fpga2_rx_checker
// Purpose  : FPGA2 responder for the 4-phase req/ack link. It checks each
//            received word against base + index and reports done/pass/timeout.
// Revision : 1.0
// ============================================================================
module fpga2_rx_checker #(
  parameter int                DATA_W         = 32,
  parameter int                NUM_WORDS      = 10,
  parameter logic [DATA_W-1:0] PATTERN_BASE   = 32'hA5A5A5A5,
  parameter int                SYNC_STAGES    = 2,
  parameter int                TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              req_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_out,
  output logic              rdy_out,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [7:0]        word_count,
  output logic [7:0]        err_count,
  output logic              done,
  output logic              pass,
  output logic              timeout
);

  localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK   = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t                  r_state;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic [c_TO_W-1:0]       r_to_cnt;
  logic                    r_ack;
  logic [DATA_W-1:0]       r_data;
  logic                    r_data_valid;
  logic [7:0]              r_word_count;
  logic [7:0]              r_err_count;
  logic                    r_done;
  logic                    r_pass;
  logic                    r_timeout;

  logic                    w_req_s;
  logic [DATA_W-1:0]       w_expected;

  assign w_req_s    = r_sync[SYNC_STAGES-1];
  assign w_expected = PATTERN_BASE + DATA_W'(r_word_count);

  // data_in is only sampled once req_s is high, so it has been stable for
  // at least SYNC_STAGES cycles and needs no synchronizer of its own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sync       <= '0;
      r_to_cnt     <= '0;
      r_ack        <= 1'b0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_word_count <= 8'd0;
      r_err_count  <= 8'd0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], req_in};
      r_data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en && w_req_s) begin
            r_data       <= data_in;
            r_data_valid <= 1'b1;
            if ((data_in != w_expected) && (r_err_count != 8'hFF))
              r_err_count <= r_err_count + 8'd1;
            r_word_count <= r_word_count + 8'd1;
            r_ack        <= 1'b1;
            r_state      <= S_ACK;
          end
        end
        S_ACK: begin
          if (!w_req_s) begin
            r_ack    <= 1'b0;
            r_to_cnt <= '0;
            if (r_word_count == 8'(NUM_WORDS)) begin
              r_done  <= 1'b1;
              r_pass  <= (r_err_count == 8'd0);
              r_state <= S_DONE;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1)) begin
            r_ack     <= 1'b0;
            r_to_cnt  <= '0;
            r_timeout <= 1'b1;
            r_state   <= S_ERROR;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_DONE;
        S_ERROR: r_state <= S_ERROR;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Held in reset means not ready, whatever en says.
  assign rdy_out    = rst_n && en && (r_state == S_IDLE);
  assign ack_out    = r_ack;
  assign data_out   = r_data;
  assign data_valid = r_data_valid;
  assign word_count = r_word_count;
  assign err_count  = r_err_count;
  assign done       = r_done;
  assign pass       = r_pass;
  assign timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_fpga2_rx_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpga2_rx_checker
// Purpose  : Directed + randomized bench for fpga2_rx_checker with a
//            word-level reference model of counts, done and pass.
// Revision : 1.0
// ============================================================================
module tb_fpga2_rx_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic [31:0] data_in = 32'd0;

  wire        ack_a, rdy_a, dv_a, done_a, pass_a, to_a;
  wire [31:0] dout_a;
  wire [7:0]  wc_a, err_a;
  wire        ack_b, rdy_b, dv_b, done_b, pass_b, to_b;
  wire [31:0] dout_b;
  wire [7:0]  wc_b, err_b;

  fpga2_rx_checker #(
    .DATA_W(32), .NUM_WORDS(10), .PATTERN_BASE(32'hA5A5A5A5),
    .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .req_in(req_a), .data_in(data_in),
    .ack_out(ack_a), .rdy_out(rdy_a), .data_out(dout_a), .data_valid(dv_a),
    .word_count(wc_a), .err_count(err_a), .done(done_a), .pass(pass_a),
    .timeout(to_a)
  );

  // Second instance exercises modulo-2^32 wrap of the expected pattern.
  fpga2_rx_checker #(
    .DATA_W(32), .NUM_WORDS(3), .PATTERN_BASE(32'hFFFFFFFF),
    .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .req_in(req_b), .data_in(data_in),
    .ack_out(ack_b), .rdy_out(rdy_b), .data_out(dout_b), .data_valid(dv_b),
    .word_count(wc_b), .err_count(err_b), .done(done_b), .pass(pass_b),
    .timeout(to_b)
  );

  always #5 clk = ~clk;

  bit          sel = 1'b0;
  wire         ack_m  = sel ? ack_b  : ack_a;
  wire         rdy_m  = sel ? rdy_b  : rdy_a;
  wire         dv_m   = sel ? dv_b   : dv_a;
  wire         done_m = sel ? done_b : done_a;
  wire         pass_m = sel ? pass_b : pass_a;
  wire         to_m   = sel ? to_b   : to_a;
  wire [31:0]  dout_m = sel ? dout_b : dout_a;
  wire [7:0]   wc_m   = sel ? wc_b   : wc_a;
  wire [7:0]   err_m  = sel ? err_b  : err_a;

  int          checks = 0;
  int          errors = 0;
  int          m_wc;
  int          m_err;
  int          m_num;
  logic [31:0] m_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v);
    if (sel) req_b = v;
    else     req_a = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_ack", ack_m, 0);
    check("rst_rdy", rdy_m, 0);
    check("rst_dv", dv_m, 0);
    check("rst_dout", dout_m, 0);
    check("rst_wc", wc_m, 0);
    check("rst_err", err_m, 0);
    check("rst_done", done_m, 0);
    check("rst_pass", pass_m, 0);
    check("rst_to", to_m, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_wc  = 0;
    m_err = 0;
  endtask

  // One full 4-phase transfer, with exact 3-edge latency in each direction.
  task automatic send_word(input logic [31:0] d);
    data_in = d;
    set_req(1'b1);
    repeat (2) begin
      @(negedge clk);
      check("ack_early", ack_m, 0);
    end
    @(negedge clk);
    if (d !== m_base + 32'(m_wc) && m_err < 255) m_err++;
    m_wc++;
    check("ack_rise", ack_m, 1);
    check("dv_pulse", dv_m, 1);
    check("data_out", dout_m, d);
    check("word_count", wc_m, 32'(m_wc));
    check("err_count", err_m, 32'(m_err));
    check("rdy_in_ack", rdy_m, 0);
    @(negedge clk);
    check("dv_one_cycle", dv_m, 0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    set_req(1'b0);
    data_in = $urandom;
    repeat (2) @(negedge clk);
    check("ack_hold", ack_m, 1);
    @(negedge clk);
    check("ack_fall", ack_m, 0);
    check("done", done_m, (m_wc == m_num) ? 1 : 0);
    check("pass", pass_m, (m_wc == m_num && m_err == 0) ? 1 : 0);
  endtask

  initial begin
    logic [31:0] w;
    sel    = 1'b0;
    m_base = 32'hA5A5A5A5;
    m_num  = 10;
    @(negedge clk);
    do_reset();

    // Reset while ack is high, then a fresh nominal run and a post-done request.
    en = 1'b1;
    data_in = m_base;
    set_req(1'b1);
    repeat (3) @(negedge clk);
    check("mid_ack", ack_m, 1);
    rst_n = 1'b0;
    set_req(1'b0);
    @(negedge clk);
    check("mid_rst_ack", ack_m, 0);
    check("mid_rst_wc", wc_m, 0);
    check("mid_rst_err", err_m, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_wc = 0;
    m_err = 0;
    for (int i = 0; i < 10; i++) send_word(m_base + 32'(i));
    check("nom_wc", wc_m, 10);
    check("nom_err", err_m, 0);
    check("nom_rdy", rdy_m, 0);
    set_req(1'b1);
    data_in = m_base + 32'd10;
    repeat (10) @(negedge clk);
    check("post_done_ack", ack_m, 0);
    check("post_done_wc", wc_m, 10);
    check("post_done_done", done_m, 1);
    set_req(1'b0);
    @(negedge clk);

    // Word 3 corrupted.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      w = (i == 3) ? 32'hA5A5A5A9 : m_base + 32'(i);
      send_word(w);
      if (i == 3) check("corrupt_err", err_m, 1);
    end
    check("corrupt_pass", pass_m, 0);
    check("corrupt_done", done_m, 1);

    // Randomized payloads, roughly one in three corrupted.
    for (int run = 0; run < 2; run++) begin
      do_reset();
      for (int i = 0; i < 10; i++) begin
        w = ($urandom_range(0, 2) == 0) ? $urandom : m_base + 32'(i);
        send_word(w);
      end
    end

    // Enable gating.
    en = 1'b0;
    do_reset();
    data_in = m_base;
    set_req(1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("en0_ack", ack_m, 0);
      check("en0_rdy", rdy_m, 0);
    end
    en = 1'b1;
    @(negedge clk);
    check("en1_ack", ack_m, 1);
    check("en1_dv", dv_m, 1);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("en_drop_ack", ack_m, 1);
    set_req(1'b0);
    repeat (3) @(negedge clk);
    check("en_drop_fall", ack_m, 0);
    check("en_drop_wc", wc_m, 1);
    check("en_drop_err", err_m, 0);

    // Timeout: sender never releases req.
    en = 1'b1;
    do_reset();
    data_in = m_base;
    set_req(1'b1);
    repeat (3) @(negedge clk);
    check("to_ack_rise", ack_m, 1);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      check("to_ack_hold", ack_m, 1);
    end
    check("to_not_yet", to_m, 0);
    @(negedge clk);
    check("to_ack_fall", ack_m, 0);
    check("to_flag", to_m, 1);
    set_req(1'b0);
    repeat (5) @(negedge clk);
    set_req(1'b1);
    repeat (10) @(negedge clk);
    check("to_ignore_ack", ack_m, 0);
    check("to_sticky", to_m, 1);
    check("to_done", done_m, 0);
    check("to_pass", pass_m, 0);
    set_req(1'b0);
    do_reset();

    // Pattern wrap: base FFFFFFFF expects 00000000 for word 1.
    sel    = 1'b1;
    m_base = 32'hFFFFFFFF;
    m_num  = 3;
    do_reset();
    send_word(32'hFFFFFFFF);
    send_word(32'h00000000);
    send_word(32'h00000001);
    check("wrap_err", err_m, 0);
    check("wrap_pass", pass_m, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpga2_rx_checker.md
Name: fpga2_rx_checker

Overview:
Responder end of the inter-FPGA 4-phase req/ack link on the FPGA 2 side. It synchronizes the incoming request and captures each 32-bit word. It checks every word against the test pattern (base + word index) and completes the handshake. It counts received words and mismatches, flags a stuck sender with a timeout, and reports done/pass for the board LED logic.

Parameters:
DATA_W, 32, width of the data bus.
NUM_WORDS, 10, words expected per test run (1..255).
PATTERN_BASE, 32'hA5A5A5A5, expected value of word 0; word i expects PATTERN_BASE + i, modulo 2^DATA_W.
SYNC_STAGES, 2, flip-flop stages on req_in (minimum 2).
TIMEOUT_CYCLES, 1000000, maximum cycles ack may stay high waiting for req_in to drop.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous, active-low reset
en  input  1  test enable; gates acceptance of new words
req_in  input  1  request from remote sender (asynchronous to clk)
data_in  input  DATA_W  data from remote sender; stable from before req_in rises until ack is seen
ack_out  output  1  acknowledge to sender (registered)
rdy_out  output  1  high when able to accept a word
data_out  output  DATA_W  last captured word
data_valid  output  1  one-cycle pulse when data_out updates
word_count  output  8  words accepted since reset
err_count  output  8  mismatching words, saturates at 255
done  output  1  NUM_WORDS accepted and handshake closed (sticky)
pass  output  1  done and err_count==0 (sticky)
timeout  output  1  ack timeout occurred (sticky)

Behaviour:
- Reset (rst_n=0 at a rising edge): all outputs are 0, the sync chain is 0, the timeout counter is 0 and the FSM is IDLE. Reset applies on the next edge from any state, including mid-handshake: ack_out drops after that edge.
- req_in passes through SYNC_STAGES flops to give req_s. data_in is not synchronized; it is sampled only when req_s=1, which guarantees at least SYNC_STAGES cycles of stability.
- FSM states: IDLE, ACK, DONE, ERROR.
- IDLE: rdy_out = en.
  - If en=1 and req_s=1:
    - data_out <= data_in and data_valid <= 1.
    - If data_in != PATTERN_BASE + word_count, err_count increments (saturating at 255).
    - word_count increments and ack_out <= 1.
    - Next state is ACK.
  - If en=0, requests are ignored and ack_out stays 0.
- ACK: ack_out=1 and rdy_out=0. The timeout counter increments each cycle.
  - If req_s=0: ack_out <= 0 and the counter clears. Next state is DONE if word_count==NUM_WORDS, otherwise IDLE.
  - If the counter reaches TIMEOUT_CYCLES-1 while req_s=1: ack_out <= 0, timeout <= 1, next state is ERROR.
  - en has no effect in ACK; a started handshake always completes.
- DONE: done=1, pass=(err_count==0), rdy_out=0, ack_out=0. Further requests are never acknowledged. The block stays in DONE until reset.
- ERROR: all handshake outputs are 0 and timeout=1. The block stays in ERROR until reset; done and pass stay 0.
- Latency, with SYNC_STAGES=2:
  - req_in rising before edge k gives ack_out=1 after edge k+2.
  - req_in falling before edge m gives ack_out=0 after edge m+2.
  - In general, latency is SYNC_STAGES+1 edges in each direction.
- data_valid is high exactly one cycle per accepted word, coincident with ack_out rising.
- A new word cannot be accepted in the cycle ack_out falls, because the FSM must pass through IDLE first. Minimum handshake period is 2*(SYNC_STAGES+1) cycles plus the sender's own delay.
- Expected-value arithmetic is DATA_W bits wide and wraps modulo 2^DATA_W (e.g. base FFFFFFFF, word 1 expects 00000000).

Test Plan:
1. Nominal run: sender sends A5A5A5A5..A5A5A5AE with a proper 4-phase handshake, en=1 -> ten data_valid pulses; word_count=10, err_count=0; done=1 and pass=1 after the 10th ack falls; rdy_out=0.
2. Corruption: word 3 sent as A5A5A5A9 instead of A5A5A5A8, all others correct -> err_count=1 after word 3; final done=1, pass=0, word_count=10.
3. Latency: raise req_in before edge 5 -> ack_out high after edge 7; drop req_in before edge 12 -> ack_out low after edge 14; data_out equals data_in as sampled at edge 7.
4. Timeout, with TIMEOUT_CYCLES=16: hold req_in high indefinitely after the first ack -> ack_out falls and timeout=1 sixteen cycles after ack rose; later req activity is ignored until rst_n pulses low.
5. Enable gating:
   - en=0 with req_in high for 20 cycles -> ack_out stays 0 and rdy_out=0; set en=1 -> ack_out high 1 cycle later.
   - Drop en while ack_out is high -> the handshake still completes normally.
6. Reset mid-handshake, then post-done traffic:
   - rst_n=0 while ack_out=1 -> next edge ack_out=0 and word_count=err_count=0; a fresh 10-word run then passes.
   - An 11th req after done -> never acknowledged.
